// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: test-pattern source for a VGA painter.
// Takes the pixel/line counters from the sync controller and produces a
// registered 24-bit color for one of four patterns (bars, checker, gradient,
// solid). A raw active-low pushbutton on 'swap' cycles the pattern. A press
// is queued and only takes effect at the frame boundary, so a frame is never
// torn between two patterns.
//
// Build option: define VGA_SWAP_DEBOUNCE_EN to include the debounce counter
// on the synchronized button level. When it is left undefined, the
// synchronized level is used directly and DEBOUNCE_CYCLES is ignored.

module vga_pattern_gen #(
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic        clk,
  input  logic        reset,     // asynchronous, active-low
  input  logic        swap,      // raw pushbutton, active-low, asynchronous
  input  logic [9:0]  h_count,
  input  logic [9:0]  v_count,
  input  logic        vid_on,
  output logic [23:0] color,
  output logic [1:0]  pattern
);

  typedef enum logic [1:0] {
    PAT_BARS     = 2'd0,
    PAT_CHECKER  = 2'd1,
    PAT_GRADIENT = 2'd2,
    PAT_SOLID    = 2'd3
  } pattern_e;

  // Active-area limits widened by one bit, so a limit of 1024 still compares
  // correctly against the 10-bit counters.
  localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
  localparam logic [10:0] V_LIM = 11'(V_ACTIVE);
  // Bar edges are elaboration-time constants; the datapath only compares.
  localparam int          BAR_W = H_ACTIVE / 8;

  // ---------------------------------------------------------------------
  // Button synchronizer
  // ---------------------------------------------------------------------
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  // Two-flop synchronizer chain for the asynchronous button.
  always_comb begin
    sync1_d = swap;
    sync2_d = sync1_q;
  end

  // Synchronizer flops reset to the released (high) level.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // values from before the edge. Blocking (=) here would let one flop see
  // another's new value in the same edge and collapse the chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  // ---------------------------------------------------------------------
  // Debounced level
  // ---------------------------------------------------------------------
  logic db_lvl_q, db_lvl_d;

`ifdef VGA_SWAP_DEBOUNCE_EN
  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;

  // Accept a new level only after it has differed from the current debounced
  // level for DEBOUNCE_CYCLES straight cycles; any bounce back restarts at 0.
  // NOTE: every signal gets a default before the if/case below. Without that,
  // a path that skips the assignment makes the signal hold its value, and
  // synthesis infers a latch.
  always_comb begin
    db_cnt_d = '0;
    db_lvl_d = db_lvl_q;
    if (sync2_q != db_lvl_q) begin
      if (db_cnt_q == CNT_LAST) begin
        db_lvl_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Debounce counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_cnt_q <= '0;
    end else begin
      db_cnt_q <= db_cnt_d;
    end
  end
`else
  // Without the debounce option, the synchronized level is the debounced level.
  always_comb begin
    db_lvl_d = sync2_q;
  end
`endif

  // Debounced level register; it also serves as the "previous level" that
  // the falling-edge press detector compares against.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_lvl_q <= 1'b1;
    end else begin
      db_lvl_q <= db_lvl_d;
    end
  end

  // ---------------------------------------------------------------------
  // Press queueing and pattern selection
  // ---------------------------------------------------------------------
  logic     press;
  logic     frame_edge;
  logic     pending_q, pending_d;
  pattern_e pattern_q, pattern_d;

  function automatic pattern_e next_pattern(input pattern_e cur);
    case (cur)
      PAT_BARS:     return PAT_CHECKER;
      PAT_CHECKER:  return PAT_GRADIENT;
      PAT_GRADIENT: return PAT_SOLID;
      default:      return PAT_BARS;
    endcase
  endfunction

  // A press is the cycle whose debounced level is about to fall, so a press
  // found in the boundary cycle itself can still be applied at that boundary.
  // Patterns change only in the single boundary cycle at the start of
  // vertical blanking. Any extra presses while one is queued are absorbed.
  always_comb begin
    press      = db_lvl_q & ~db_lvl_d;
    frame_edge = ({1'b0, v_count} == V_LIM) && (h_count == 10'd0);
    pattern_d  = pattern_q;
    pending_d  = pending_q | press;
    if (frame_edge && (pending_q || press)) begin
      pattern_d = next_pattern(pattern_q);
      pending_d = 1'b0;
    end
  end

  // Pattern index and pending-press flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pattern_q <= PAT_BARS;
      pending_q <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      pending_q <= pending_d;
    end
  end

  // ---------------------------------------------------------------------
  // Pixel color
  // ---------------------------------------------------------------------
  function automatic logic [23:0] bar_color(input logic [9:0] h);
    logic [10:0] hx;
    hx = {1'b0, h};
    if      (hx < 11'(1 * BAR_W)) return 24'hFFFFFF;
    else if (hx < 11'(2 * BAR_W)) return 24'hFFFF00;
    else if (hx < 11'(3 * BAR_W)) return 24'h00FFFF;
    else if (hx < 11'(4 * BAR_W)) return 24'h00FF00;
    else if (hx < 11'(5 * BAR_W)) return 24'hFF00FF;
    else if (hx < 11'(6 * BAR_W)) return 24'hFF0000;
    else if (hx < 11'(7 * BAR_W)) return 24'h0000FF;
    else                          return 24'h000000;
  endfunction

  logic        in_active;
  logic [23:0] color_q, color_d;

  // Next-pixel color from the current counters and pattern. Outside the
  // active area the output is black.
  always_comb begin
    in_active = vid_on && ({1'b0, h_count} < H_LIM) && ({1'b0, v_count} < V_LIM);
    color_d   = 24'h000000;
    if (in_active) begin
      case (pattern_q)
        PAT_BARS:     color_d = bar_color(h_count);
        PAT_CHECKER:  color_d = (h_count[5] ^ v_count[5]) ? 24'hFFFFFF : 24'h000000;
        PAT_GRADIENT: color_d = {h_count[9:2], v_count[8:1], 8'h80};
        default:      color_d = 24'h2040C0;
      endcase
    end
  end

  // One-cycle registered color output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      color_q <= 24'h000000;
    end else begin
      color_q <= color_d;
    end
  end

  assign color   = color_q;
  assign pattern = pattern_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Testbench for vga_pattern_gen. The stimulus process drives the counters
// and button and pushes each expected {color, pattern} into a scoreboard
// queue. A monitor pops one entry one clock after each tagged input cycle
// and compares.
module tb_vga_pattern_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        swap;
  logic [9:0]  h_count;
  logic [9:0]  v_count;
  logic        vid_on;
  logic [23:0] color;
  logic [1:0]  pattern;

  always #5 clk = ~clk;

  vga_pattern_gen #(
    .H_ACTIVE       (640),
    .V_ACTIVE       (480),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .clk    (clk),
    .reset  (rst_n),
    .swap   (swap),
    .h_count(h_count),
    .v_count(v_count),
    .vid_on (vid_on),
    .color  (color),
    .pattern(pattern)
  );

  // Cycles from driving swap low until the press is seen combinationally.
`ifdef VGA_SWAP_DEBOUNCE_EN
  localparam int PRESS_LAT = 17;
`else
  localparam int PRESS_LAT = 2;
`endif

  typedef struct {
    string       name;
    logic [23:0] col;
    logic [1:0]  pat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  logic exp_valid = 1'b0;
  logic tag_q     = 1'b0;
  logic [1:0] ep;

  task automatic check(input string nm, input logic [23:0] act, input logic [23:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %06h want %06h", nm, act, req);
    end
  endtask

  // Monitor: an input cycle tagged for checking is answered one edge later.
  always @(posedge clk) tag_q <= exp_valid;

  always @(negedge clk) begin
    if (tag_q) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty: got 0 entries want 1");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_color"}, color, e.col);
        check({e.name, "_pattern"}, {22'd0, pattern}, {22'd0, e.pat});
      end
    end
  end

  // One input cycle; optionally queue the expected response.
  task automatic cyc(input logic [9:0] hh, input logic [9:0] vv, input logic von,
                     input bit en, input logic [23:0] ec, input logic [1:0] epat,
                     input string nm);
    @(negedge clk);
    h_count   = hh;
    v_count   = vv;
    vid_on    = von;
    exp_valid = en;
    if (en) sb.push_back('{name: nm, col: ec, pat: epat});
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(10'd5, 10'd100, 1'b1, 1'b0, 24'h0, 2'd0, "");
  endtask

  task automatic press();
    swap = 1'b0;
    idle(20);
    swap = 1'b1;
    idle(25);
  endtask

  task automatic boundary(input logic [1:0] epat, input string nm);
    cyc(10'd0, 10'd480, 1'b0, 1'b1, 24'h000000, epat, nm);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1; swap = 1'b1;
    h_count = 10'd5; v_count = 10'd100; vid_on = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("reset_color", color, 24'h0);
    check("reset_pattern", {22'd0, pattern}, 24'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // BARS, boundaries of bars and of the active area.
    cyc(10'd100, 10'd10, 1'b1, 1'b1, 24'hFFFF00, 2'd0, "bars_h100");
    cyc(10'd79,  10'd10, 1'b1, 1'b1, 24'hFFFFFF, 2'd0, "bars_h79");
    cyc(10'd80,  10'd10, 1'b1, 1'b1, 24'hFFFF00, 2'd0, "bars_h80");
    cyc(10'd200, 10'd10, 1'b1, 1'b1, 24'h00FFFF, 2'd0, "bars_h200");
    cyc(10'd300, 10'd10, 1'b1, 1'b1, 24'h00FF00, 2'd0, "bars_h300");
    cyc(10'd399, 10'd10, 1'b1, 1'b1, 24'hFF00FF, 2'd0, "bars_h399");
    cyc(10'd479, 10'd10, 1'b1, 1'b1, 24'hFF0000, 2'd0, "bars_h479");
    cyc(10'd480, 10'd10, 1'b1, 1'b1, 24'h0000FF, 2'd0, "bars_h480");
    cyc(10'd559, 10'd10, 1'b1, 1'b1, 24'h0000FF, 2'd0, "bars_h559");
    cyc(10'd560, 10'd10, 1'b1, 1'b1, 24'h000000, 2'd0, "bars_h560");
    cyc(10'd640, 10'd10, 1'b1, 1'b1, 24'h000000, 2'd0, "h_out_of_range");
    cyc(10'd5,  10'd480, 1'b1, 1'b1, 24'h000000, 2'd0, "v_out_of_range");
    cyc(10'd100, 10'd10, 1'b0, 1'b1, 24'h000000, 2'd0, "vid_off");
    boundary(2'd0, "boundary_no_press");

    // Press mid-frame; the pattern holds until the boundary, then CHECKER.
    press();
    cyc(10'd0, 10'd479, 1'b1, 1'b1, 24'hFFFFFF, 2'd0, "pend_v479");
    cyc(10'd1, 10'd480, 1'b1, 1'b1, 24'h000000, 2'd0, "pend_h1_v480");
    boundary(2'd1, "boundary_to_checker");
    cyc(10'd32, 10'd0,  1'b1, 1'b1, 24'hFFFFFF, 2'd1, "chk_h32_v0");
    cyc(10'd32, 10'd0,  1'b0, 1'b1, 24'h000000, 2'd1, "chk_h32_v0_off");
    cyc(10'd32, 10'd32, 1'b1, 1'b1, 24'h000000, 2'd1, "chk_h32_v32");
    cyc(10'd0,  10'd32, 1'b1, 1'b1, 24'hFFFFFF, 2'd1, "chk_h0_v32");

    // GRADIENT.
    press();
    boundary(2'd2, "boundary_to_gradient");
    cyc(10'd400, 10'd300, 1'b1, 1'b1, 24'h649680, 2'd2, "grad_400_300");
    cyc(10'd400, 10'd300, 1'b0, 1'b1, 24'h000000, 2'd2, "grad_vid_off");
    cyc(10'd0,   10'd0,   1'b1, 1'b1, 24'h000080, 2'd2, "grad_0_0");
    cyc(10'd639, 10'd479, 1'b1, 1'b1, 24'h9FEF80, 2'd2, "grad_639_479");

    // Bouncing button: rejected with debounce, one absorbed press without.
    repeat (20) begin
      swap = 1'b0; idle(5);
      swap = 1'b1; idle(5);
    end
    idle(30);
`ifdef VGA_SWAP_DEBOUNCE_EN
    boundary(2'd2, "boundary_after_bounce");
    press();
    boundary(2'd3, "boundary_to_solid");
`else
    boundary(2'd3, "boundary_after_bounce");
`endif
    cyc(10'd100, 10'd100, 1'b1, 1'b1, 24'h2040C0, 2'd3, "solid");
    idle(2);

    // Reset mid-frame and mid-press: immediate clear, partial press lost.
    swap = 1'b0;
    idle(8);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_color", color, 24'h0);
    check("midreset_pattern", {22'd0, pattern}, 24'd0);
    swap = 1'b1;
    idle(3);
    check("midreset_hold_color", color, 24'h0);
    rst_n = 1'b1;
    cyc(10'd100, 10'd10, 1'b1, 1'b1, 24'hFFFF00, 2'd0, "post_reset_bars");
    idle(30);
    boundary(2'd0, "post_reset_boundary");

    // Four presses from reset: 1, 2, 3, then a press seen in the boundary cycle.
    ep = 2'd0;
    repeat (3) begin
      press();
      ep = ep + 2'd1;
      boundary(ep, "seq_boundary");
    end
    idle(1);
    swap = 1'b0;
    repeat (PRESS_LAT - 2) idle(1);
    cyc(10'd5, 10'd100, 1'b1, 1'b1, 24'h2040C0, 2'd3, "pre_edge_hold");
    boundary(2'd0, "press_in_boundary");
    swap = 1'b1;
    idle(30);
    boundary(2'd0, "no_double_advance");
    cyc(10'd100, 10'd10, 1'b1, 1'b1, 24'hFFFF00, 2'd0, "wrap_bars");

    // Three clean presses in one frame advance by exactly one.
    press(); press(); press();
    cyc(10'd1, 10'd480, 1'b1, 1'b1, 24'h000000, 2'd0, "three_pre_edge");
    boundary(2'd1, "three_presses");
    cyc(10'd0, 10'd32, 1'b1, 1'b1, 24'hFFFFFF, 2'd1, "three_checker");

    // Drain the scoreboard.
    idle(3);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
